uart_tx_buffered: RTL and testbench

//   Transmit side of the perceptron UART link, 8N1, LSB first. Buffers result

---
 rtl/uart_tx_buffered_pkg.sv | 19 +
 rtl/uart_tx_buffered_sync_fifo.sv | 51 +++++
 rtl/uart_tx_buffered.sv | 140 ++++++++++++++
 tb/tb_uart_tx_buffered.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_buffered_pkg.sv
// Shared UART framing constants and serialiser state encoding.
// The UART receiver imports the same package.
package uart_tx_buffered_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  function automatic int calc_baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Single-clock FIFO with occupancy count; depth must be a power of two
// so the pointers wrap by natural overflow.
module sync_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [width-1:0]         din,
  output logic [width-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   count
);

  localparam int AW = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             wr_ok, rd_ok;

  assign full  = (count == (AW+1)'(depth));
  assign empty = (count == '0);
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// 8N1 LSB-first UART transmitter fed by a small FIFO; frames are sent
// back-to-back with no idle gap while the FIFO holds data.
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int clock_frequency = 12000000,
  parameter int uart_baud_rate  = 9600,
  parameter int fifo_depth      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    data_in,
  input  logic                          data_valid,
  output logic                          data_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(fifo_depth):0]   fifo_count
);

  localparam int BAUD_DIV = calc_baud_div(clock_frequency, uart_baud_rate);
  localparam int BW       = (BAUD_DIV < 2) ? 1 : $clog2(BAUD_DIV);

  if (BAUD_DIV < 2) begin : g_bad_baud
    $error("uart_tx_buffered: BAUD_DIV must be at least 2");
  end
  if (fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_buffered: fifo_depth must be a power of two >= 2");
  end

  tx_state_e   state, state_n;
  logic [BW-1:0] baud_cnt, baud_n;
  logic [2:0]  bit_idx, bit_n;
  logic [7:0]  shifter, shift_n;
  logic        tx_n;
  logic        pop, push;
  logic        baud_done;
  logic [7:0]  fifo_dout;
  logic        fifo_full, fifo_empty;

  assign push       = data_valid && !fifo_full;
  assign data_ready = !fifo_full;
  assign baud_done  = (baud_cnt == BW'(BAUD_DIV - 1));
  assign busy       = (state != ST_IDLE) || (fifo_count != '0);

  sync_fifo #(
    .width (8),
    .depth (fifo_depth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (push),
    .rd_en (pop),
    .din   (data_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shifter  <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      shifter  <= shift_n;
      tx       <= tx_n;
    end
  end

  // tx is registered: each transition decides the level of the next bit period.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    shift_n = shifter;
    tx_n    = tx;
    pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        baud_n = '0;
        bit_n  = '0;
        tx_n   = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = fifo_dout;
          tx_n    = 1'b0;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (baud_done) begin
          baud_n  = '0;
          tx_n    = shifter[0];
          state_n = ST_DATA;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_n = '0;
          if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
            bit_n   = '0;
            tx_n    = 1'b1;
            state_n = ST_STOP;
          end else begin
            bit_n   = bit_idx + 1'b1;
            shift_n = shifter >> 1;
            tx_n    = shifter[1];
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          baud_n = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = fifo_dout;
            tx_n    = 1'b0;
            state_n = ST_START;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Two instances (default line rate and a 16-cycle bit) checked every cycle
// against a frame-timeline model of queued bytes.
module tb_uart_tx_buffered;

  localparam int BA    = 1250;
  localparam int BB    = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, va, ready_a, tx_a, busy_a;
  logic       rst_b, vb, ready_b, tx_b, busy_b;
  logic [7:0] da, db;
  logic [2:0] cnt_a, cnt_b;

  uart_tx_buffered u_dut_a (
    .clk(clk), .rst(rst_a), .data_in(da), .data_valid(va), .data_ready(ready_a),
    .tx(tx_a), .busy(busy_a), .fifo_count(cnt_a)
  );

  uart_tx_buffered #(.clock_frequency(16), .uart_baud_rate(1), .fifo_depth(DEPTH)) u_dut_b (
    .clk(clk), .rst(rst_b), .data_in(db), .data_valid(vb), .data_ready(ready_b),
    .tx(tx_b), .busy(busy_b), .fifo_count(cnt_b)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Model: a queue of waiting bytes plus the edge at which the current frame began.
  logic [7:0] q0[$], q1[$];
  int         ecnt = 0;
  bit         act[2];
  int         st[2];
  logic [9:0] frm[2];
  bit         acc[2];

  task automatic model_step(input int i, input logic r, input logic v,
                            input logic [7:0] d, input int b);
    logic [7:0] q[$];
    int pre;
    if (i == 0) q = q0; else q = q1;
    acc[i] = 1'b0;
    if (r) begin
      q.delete();
      act[i] = 1'b0;
    end else begin
      pre = q.size();
      if (act[i] && (ecnt - st[i]) == 10*b) act[i] = 1'b0;
      if (!act[i] && pre > 0) begin
        frm[i] = {1'b1, q.pop_front(), 1'b0};
        st[i]  = ecnt;
        act[i] = 1'b1;
      end
      if (v && pre < DEPTH) begin
        q.push_back(d);
        acc[i] = 1'b1;
      end
    end
    if (i == 0) q0 = q; else q1 = q;
  endtask

  function automatic logic exp_tx(input int i, input int b);
    if (!act[i]) return 1'b1;
    return frm[i][(ecnt - st[i]) / b];
  endfunction

  always @(posedge clk) begin
    ecnt++;
    model_step(0, rst_a, va, da, BA);
    model_step(1, rst_b, vb, db, BB);
  end

  always @(negedge clk) begin
    chk("a_tx",    tx_a,    exp_tx(0, BA));
    chk("a_busy",  busy_a,  act[0] || q0.size() != 0);
    chk("a_count", cnt_a,   q0.size());
    chk("a_ready", ready_a, q0.size() < DEPTH);
    chk("b_tx",    tx_b,    exp_tx(1, BB));
    chk("b_busy",  busy_b,  act[1] || q1.size() != 0);
    chk("b_count", cnt_b,   q1.size());
    chk("b_ready", ready_b, q1.size() < DEPTH);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_now(input int i);
    if (i == 0) begin rst_a = 1'b1; q0.delete(); act[0] = 1'b0; end
    else        begin rst_b = 1'b1; q1.delete(); act[1] = 1'b0; end
  endtask

  task automatic drain_b(input string tag);
    int g = 0;
    while ((act[1] || q1.size() != 0) && g < 20000) begin tick(); g++; end
    chk(tag, act[1] || q1.size() != 0, 0);
  endtask

  task automatic burst(input int n, input logic [7:0] base);
    int k = 0, g = 0;
    int e_first = 0, e_fifth = 0, e_sixth = 0;
    vb = 1'b1;
    db = base;
    while (k < n && g < 5000) begin
      tick();
      g++;
      if (acc[1]) begin
        if (k == 0) e_first = ecnt;
        if (k == 4) begin e_fifth = ecnt; chk("burst_ready_low", ready_b, 0); end
        if (k == 5) e_sixth = ecnt;
        k++;
        db = base + 8'(k);
      end
    end
    vb = 1'b0;
    chk("burst_accepted", k, n);
    chk("burst_5_consecutive", e_fifth - e_first, 4);
    chk("burst_6th_at_frame2", e_sixth - e_first, 10*BB + 2);
  endtask

  task automatic reset_mid(input int fbit);
    int g = 0;
    drain_b("rm_drain_pre");
    vb = 1'b1;
    db = 8'h3C; tick();
    db = 8'($urandom); tick();
    db = 8'($urandom); tick();
    vb = 1'b0;
    chk("rm_queued", cnt_b, 2);
    while (!(act[1] && (ecnt - st[1]) == fbit*BB + BB/2) && g < 2000) begin tick(); g++; end
    chk("rm_reached_bit", g < 2000, 1);
    chk("rm_tx_before", tx_b, frm[1][fbit]);
    reset_now(1);
    #1;
    chk("rm_tx_async", tx_b, 1);
    chk("rm_count", cnt_b, 0);
    chk("rm_busy", busy_b, 0);
    chk("rm_ready", ready_b, 1);
    tick(); tick();
    rst_b = 1'b0;
    tick();
    vb = 1'b1; db = 8'h81; tick();
    vb = 1'b0; db = 8'($urandom);
    drain_b("rm_drain_post");
  endtask

  initial begin
    int n, k, g;
    rst_a = 1'b1; rst_b = 1'b1;
    va = 1'b0; vb = 1'b0; da = '0; db = '0;
    repeat (3) tick();
    chk("rst_tx", tx_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_count", cnt_a, 0);
    chk("rst_ready", ready_a, 1);
    rst_a = 1'b0; rst_b = 1'b0;
    tick();

    // Single 0xA5 at the default line rate; data_in changes right after accept.
    va = 1'b1; da = 8'hA5; tick();
    va = 1'b0; da = 8'($urandom);
    chk("a5_tx_hold", tx_a, 1);
    tick();
    chk("a5_tx_fall", tx_a, 0);
    n = 1;
    while (busy_a && n < 13000) begin tick(); n++; end
    chk("a5_busy_cycles", n, 12501);

    // Reset while idle.
    reset_now(0);
    #1;
    chk("idle_rst_tx", tx_a, 1);
    chk("idle_rst_ready", ready_a, 1);
    tick();
    rst_a = 1'b0;
    tick();

    burst(6, 8'h00);
    drain_b("burst6_drain");

    // Push on the exact edge where STOP pops the next byte.
    vb = 1'b1;
    repeat (3) begin db = 8'($urandom); tick(); end
    vb = 1'b0;
    chk("pp_queued", cnt_b, 2);
    g = 0;
    while (!(act[1] && (ecnt - st[1]) == 10*BB - 1) && g < 2000) begin tick(); g++; end
    vb = 1'b1; db = 8'($urandom); tick();
    vb = 1'b0;
    chk("pp_count", cnt_b, 2);
    drain_b("pp_drain");

    reset_mid(4);
    reset_mid(2);

    burst(10, 8'h40);
    drain_b("wrap_drain");

    k = 0; g = 0;
    while (k < 30 && g < 20000) begin
      vb = ($urandom_range(0, 2) == 0);
      db = 8'($urandom);
      tick();
      if (acc[1]) k++;
      g++;
    end
    vb = 1'b0;
    chk("rand_accepted", k, 30);
    drain_b("rand_drain");
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
